// File: rtl/gfx_pkg.sv
// Shared types and constants for the framebuffer draw path.
package gfx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SPAN,
    S_STEP,
    S_DONE
  } state_t;

  localparam int BYTES_PER_PIXEL = 2;

  // Signed internal coordinate width: two spare bits so deltas and clipped
  // span candidates never wrap.
  function automatic int coord_w(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// Bresenham walker in a major/minor frame: loads the ordered endpoints on
// setup_i and advances one major step per step_i.
module bresenham_stepper
  import gfx_pkg::*;
#(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = coord_w(XW, YW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 setup_i,
  input  logic                 step_i,
  input  logic [XW-1:0]        x0_i,
  input  logic [XW-1:0]        x1_i,
  input  logic [YW-1:0]        y0_i,
  input  logic [YW-1:0]        y1_i,
  output logic                 steep_o,
  output logic signed [CW-1:0] maj_o,
  output logic signed [CW-1:0] min_o,
  output logic                 last_o
);
  localparam int EW = CW + 1;

  logic signed [CW-1:0] sx0, sy0, sx1, sy1, dx, dy, adx, ady;
  logic signed [CW-1:0] a0, b0, a1, b1, ms, ns, me, ne, dmaj, dmin_r, dmin;
  logic signed [EW-1:0] err_init, err_sum, err_d, err_q;
  logic signed [CW-1:0] maj_q, min_q, end_q, dmaj_q, dmin_q, min_d;
  logic                 steep_c, up_c, steep_q, up_q;

  assign sx0 = $signed(CW'(x0_i));
  assign sx1 = $signed(CW'(x1_i));
  assign sy0 = $signed(CW'(y0_i));
  assign sy1 = $signed(CW'(y1_i));

  always_comb begin
    dx      = sx1 - sx0;
    dy      = sy1 - sy0;
    adx     = (dx < 0) ? -dx : dx;
    ady     = (dy < 0) ? -dy : dy;
    steep_c = (ady > adx);
    a0      = steep_c ? sy0 : sx0;
    b0      = steep_c ? sx0 : sy0;
    a1      = steep_c ? sy1 : sx1;
    b1      = steep_c ? sx1 : sy1;
    // Walk the major axis upwards regardless of endpoint order.
    if (a0 > a1) begin
      ms = a1; ns = b1; me = a0; ne = b0;
    end else begin
      ms = a0; ns = b0; me = a1; ne = b1;
    end
    dmaj     = me - ms;
    dmin_r   = ne - ns;
    dmin     = (dmin_r < 0) ? -dmin_r : dmin_r;
    up_c     = (ne > ns);
    err_init = -($signed(EW'(dmaj)) >>> 1);
  end

  always_comb begin
    err_sum = err_q + EW'(dmin_q);
    err_d   = err_sum;
    min_d   = min_q;
    if (err_sum > 0) begin
      min_d = up_q ? min_q + CW'(1) : min_q - CW'(1);
      err_d = err_sum - EW'(dmaj_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steep_q <= 1'b0;
      up_q    <= 1'b0;
      maj_q   <= '0;
      min_q   <= '0;
      end_q   <= '0;
      dmaj_q  <= '0;
      dmin_q  <= '0;
      err_q   <= '0;
    end else if (setup_i) begin
      steep_q <= steep_c;
      up_q    <= up_c;
      maj_q   <= ms;
      min_q   <= ns;
      end_q   <= me;
      dmaj_q  <= dmaj;
      dmin_q  <= dmin;
      err_q   <= err_init;
    end else if (step_i) begin
      maj_q <= maj_q + CW'(1);
      min_q <= min_d;
      err_q <= err_d;
    end
  end

  assign steep_o = steep_q;
  assign maj_o   = maj_q;
  assign min_o   = min_q;
  assign last_o  = (maj_q == end_q);

endmodule

// File: rtl/thick_line_engine.sv
// Thick-line rasteriser: Bresenham major-axis walk emitting a clipped,
// centred minor-axis span of pixels per step over a valid/ready write port.
module thick_line_engine
  import gfx_pkg::*;
#(
  parameter int          XW      = 9,
  parameter int          YW      = 8,
  parameter int          TW      = 9,
  parameter int          SCR_W   = 320,
  parameter int          SCR_H   = 240,
  parameter logic [31:0] FB_BASE = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          abort,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [TW-1:0] thick,
  input  logic [15:0]   color,
  output logic          busy,
  output logic          done,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [31:0]   pix_addr,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [15:0]   pix_color
);
  localparam int CW = coord_w(XW, YW);

  state_t               state_q, state_d;
  logic [XW-1:0]        x0_q, x1_q;
  logic [YW-1:0]        y0_q, y1_q;
  logic [TW-1:0]        t_q, k_q, k_d, off;
  logic [15:0]          color_q;
  logic                 latch, setup, step, adv;
  logic                 steep, last, in_rng, span_end;
  logic signed [CW-1:0] maj, mnr, off_e, k_e, cand, px, py;
  logic [31:0]          lin;

  bresenham_stepper #(.XW(XW), .YW(YW), .CW(CW)) u_stepper (
    .clk     (clk),
    .rst     (reset),
    .setup_i (setup),
    .step_i  (step),
    .x0_i    (x0_q),
    .x1_i    (x1_q),
    .y0_i    (y0_q),
    .y1_i    (y1_q),
    .steep_o (steep),
    .maj_o   (maj),
    .min_o   (mnr),
    .last_o  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      t_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (latch) begin
        x0_q    <= x0;
        x1_q    <= x1;
        y0_q    <= y0;
        y1_q    <= y1;
        t_q     <= (thick == '0) ? TW'(1) : thick;
        color_q <= color;
      end
    end
  end

  // Span candidate centred on the line; k sweeps the minor axis upwards.
  assign off      = (t_q - TW'(1)) >> 1;
  assign off_e    = $signed(CW'(off));
  assign k_e      = $signed(CW'(k_q));
  assign cand     = mnr - off_e + k_e;
  assign px       = steep ? cand : maj;
  assign py       = steep ? maj : cand;
  assign in_rng   = (px >= 0) && (px < SCR_W) && (py >= 0) && (py < SCR_H);
  assign span_end = (k_q == t_q - TW'(1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    latch     = 1'b0;
    setup     = 1'b0;
    step      = 1'b0;
    pix_valid = 1'b0;
    adv       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          latch   = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        setup   = 1'b1;
        k_d     = '0;
        state_d = S_SPAN;
      end
      S_SPAN: begin
        pix_valid = in_rng;
        adv       = in_rng ? pix_ready : 1'b1;
        if (adv) begin
          if (span_end) state_d = last ? S_DONE : S_STEP;
          else          k_d     = k_q + TW'(1);
        end
      end
      S_STEP: begin
        step    = 1'b1;
        k_d     = '0;
        state_d = S_SPAN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over a same-cycle handshake: that pixel is not written.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      pix_valid = 1'b0;
      setup     = 1'b0;
      step      = 1'b0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign lin       = 32'(py) * 32'(SCR_W) + 32'(px);
  assign pix_x     = pix_valid ? px[XW-1:0] : '0;
  assign pix_y     = pix_valid ? py[YW-1:0] : '0;
  assign pix_addr  = pix_valid ? FB_BASE + lin * 32'(BYTES_PER_PIXEL) : '0;
  assign pix_color = color_q;

endmodule
